// File: rtl/fpga_cfg_pkg.sv
// Shared types for the configuration frame receiver:
// FSM state encoding and first-error cause codes.
package fpga_cfg_pkg;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      DONE,
      ERR
   } state_e;

   localparam logic [2:0] ERR_NONE      = 3'd0;
   localparam logic [2:0] ERR_ONEHOT    = 3'd1;
   localparam logic [2:0] ERR_ORDER     = 3'd2;
   localparam logic [2:0] ERR_LATE      = 3'd3;
   localparam logic [2:0] ERR_PREMATURE = 3'd4;

endpackage

// File: rtl/cfg_onehot_decode.sv
// One-hot frame-select decoder: bit position and
// one-hot integrity flag of an enable vector.
module cfg_onehot_decode #(
   parameter int EN_W  = 245,
   parameter int IDX_W = $clog2(EN_W)
) (
   input  logic [EN_W-1:0]  vec_i,
   output logic [IDX_W-1:0] idx_o,
   output logic             onehot_o
);

   // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
   assign onehot_o = (vec_i != '0) &&
                     ((vec_i & (vec_i - EN_W'(1))) == '0);

   // OR of set-bit positions; only meaningful when onehot_o is high.
   always_comb begin
      idx_o = '0;
      for (int i = 0; i < EN_W; i++) begin
         if (vec_i[i]) idx_o = idx_o | IDX_W'(i);
      end
   end

endmodule

// File: rtl/fpga_cfg_frame_rx.sv
// Fabric-side configuration frame receiver: commits one
// frame per one-hot enable advance and gates user-flop enable.
module fpga_cfg_frame_rx
   import fpga_cfg_pkg::*;
#(
   parameter  int WORD_W     = 224,
   parameter  int NUM_FRAMES = 244,
   localparam int EN_W       = NUM_FRAMES + 1,
   localparam int IDX_W      = $clog2(EN_W)
) (
   input  logic              clock,
   input  logic              rst,
   input  logic [WORD_W-1:0] configs_in,
   input  logic [EN_W-1:0]   configs_en,
   input  logic              ff_en,
   output logic              frame_we,
   output logic [IDX_W-1:0]  frame_idx,
   output logic [WORD_W-1:0] frame_data,
   output logic [IDX_W-1:0]  frames_loaded,
   output logic              cfg_done,
   output logic              cfg_err,
   output logic [2:0]        err_code,
   output logic              fabric_en
);

   localparam logic [EN_W-1:0]  EN_BIT0 = EN_W'(1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_FRAMES - 1);

   state_e            state_q;
   logic [EN_W-1:0]   en_q;
   logic [WORD_W-1:0] data_q;
   logic [IDX_W-1:0]  cnt_q;
   logic [IDX_W-1:0]  idx_q_q;
   logic [WORD_W-1:0] fdata_q;
   logic              we_q;
   logic              done_q;
   logic              err_q;
   logic [2:0]        code_q;
   logic              fen_q;

   logic [IDX_W-1:0]  idx_old;
   logic [IDX_W-1:0]  idx_new;
   logic              oh_old;
   logic              oh_new;
   logic              chg;
   logic              adv_ok;
   logic [2:0]        err_d;

   cfg_onehot_decode #(.EN_W(EN_W), .IDX_W(IDX_W)) u_dec_old (
      .vec_i    (en_q),
      .idx_o    (idx_old),
      .onehot_o (oh_old)
   );

   cfg_onehot_decode #(.EN_W(EN_W), .IDX_W(IDX_W)) u_dec_new (
      .vec_i    (configs_en),
      .idx_o    (idx_new),
      .onehot_o (oh_new)
   );

   assign chg    = (configs_en != en_q);
   assign adv_ok = oh_old && oh_new &&
                   (idx_new == idx_old + IDX_W'(1)) &&
                   (idx_old == cnt_q);

   // Classify this cycle's error; one-hot violations outrank ordering and premature enable.
   always_comb begin
      err_d = ERR_NONE;
      unique case (state_q)
         IDLE, LOAD: begin
            if (chg && !oh_new)      err_d = ERR_ONEHOT;
            else if (chg && !adv_ok) err_d = ERR_ORDER;
            else if (ff_en)          err_d = ERR_PREMATURE;
         end
         DONE: begin
            if (chg) err_d = ERR_LATE;
         end
         default: err_d = ERR_NONE;
      endcase
   end

   // Load FSM with input capture, frame commit, sticky first error and fabric enable gating.
   always_ff @(posedge clock or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         en_q    <= EN_BIT0;
         data_q  <= '0;
         cnt_q   <= '0;
         idx_q_q <= '0;
         fdata_q <= '0;
         we_q    <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         code_q  <= ERR_NONE;
         fen_q   <= 1'b0;
      end else begin
         en_q   <= configs_en;
         data_q <= configs_in;
         we_q   <= 1'b0;
         fen_q  <= ff_en && (state_q == DONE) && (err_d == ERR_NONE);
         if (err_d != ERR_NONE) begin
            state_q <= ERR;
            err_q   <= 1'b1;
            code_q  <= err_d;
            done_q  <= 1'b0;
         end else begin
            unique case (state_q)
               IDLE, LOAD: begin
                  if (chg) begin
                     we_q    <= 1'b1;
                     idx_q_q <= idx_old;
                     fdata_q <= data_q;
                     cnt_q   <= idx_old + IDX_W'(1);
                     if (idx_old == IDX_LAST) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                     end else begin
                        state_q <= LOAD;
                     end
                  end
               end
               DONE: state_q <= DONE;
               default: begin
                  state_q <= ERR;
                  done_q  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign frame_we      = we_q;
   assign frame_idx     = idx_q_q;
   assign frame_data    = fdata_q;
   assign frames_loaded = cnt_q;
   assign cfg_done      = done_q;
   assign cfg_err       = err_q;
   assign err_code      = code_q;
   assign fabric_en     = fen_q;

endmodule
